// File: rtl/flexbex_pkg.sv
// Shared data-bus constants and responder state encoding.
// No ports: imported by the responder, its RAM and its bus interface.
package flexbex_pkg;

    localparam int unsigned DBUS_AW   = 32;
    localparam int unsigned DBUS_DW   = 32;
    localparam int unsigned DBUS_BEW  = 4;

    // Wait counter is wide enough for the 0..15 grant wait range
    localparam int unsigned GNT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_e;

endpackage

// File: rtl/flexbex_data_mem_responder_if.sv
// Core data bus (req/gnt/rvalid) bundle between the LSU and a memory responder.
// Signals:
//   data_req_i / data_gnt_o         request and grant handshake
//   data_addr_i / data_we_i         byte address and write strobe
//   data_be_i / data_wdata_i        byte enables and lane-aligned write data
//   data_rvalid_o / data_err_o      response valid and error flag
//   data_rdata_o                    read data
// Modports: master (initiator/LSU side), slave (responder side).
interface flexbex_data_mem_responder_if;
    import flexbex_pkg::*;

    logic                data_req_i;
    logic                data_gnt_o;
    logic                data_rvalid_o;
    logic                data_err_o;
    logic [DBUS_AW-1:0]  data_addr_i;
    logic                data_we_i;
    logic [DBUS_BEW-1:0] data_be_i;
    logic [DBUS_DW-1:0]  data_wdata_i;
    logic [DBUS_DW-1:0]  data_rdata_o;

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o
    );

endinterface

// File: rtl/flexbex_data_mem_array.sv
// Single-port synchronous data RAM with per-byte write enables and a
// registered read port. Contents are never reset.
// Ports:
//   clk      clock
//   i_en     access enable (one access per cycle)
//   i_we     1 = byte-enabled write, 0 = word read
//   i_be     byte-lane write enables
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  read data, valid the cycle after a read access
module flexbex_data_mem_array
    import flexbex_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DBUS_BEW-1:0]   i_be,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DBUS_DW-1:0]    i_wdata,
    output logic [DBUS_DW-1:0]    o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DBUS_DW-1:0] r_mem [DEPTH];
    logic [DBUS_DW-1:0] r_rdata;

    // Write only enabled lanes; reads capture the whole word
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int n = 0; n < int'(DBUS_BEW); n++) begin
                    if (i_be[n]) begin
                        r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/flexbex_data_mem_responder.sv
// Memory-side responder for the core data bus: grants one transfer per
// request (after GNT_WAIT held cycles), performs the RAM access at the grant
// edge and returns exactly one response the following cycle.
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   data bus, slave side (see flexbex_data_mem_responder_if)
module flexbex_data_mem_responder
    import flexbex_pkg::*;
#(
    parameter int unsigned        ADDR_WIDTH = 10,
    parameter logic [DBUS_AW-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned        GNT_WAIT   = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    flexbex_data_mem_responder_if.slave  bus
);

    localparam logic                 NO_WAIT   = (GNT_WAIT == 0);
    localparam logic [GNT_CNT_W-1:0] WAIT_LOAD = GNT_CNT_W'((GNT_WAIT == 0) ? 0 : GNT_WAIT - 1);

    resp_state_e            r_state;
    resp_state_e            w_state_nxt;
    logic [GNT_CNT_W-1:0]   r_cnt;
    logic [GNT_CNT_W-1:0]   w_cnt_nxt;
    logic                   w_gnt;
    logic [DBUS_AW-1:0]     w_off;
    logic                   w_in_range;
    logic [ADDR_WIDTH-1:0]  w_idx;
    logic                   r_rvalid;
    logic                   r_err;
    logic                   r_rd;
    logic [DBUS_DW-1:0]     w_ram_rdata;

    // Range decode: addresses below the base wrap high and fall out of range
    assign w_off      = bus.data_addr_i - BASE_ADDR;
    assign w_in_range = (w_off >> (ADDR_WIDTH + 2)) == '0;
    assign w_idx      = w_off[ADDR_WIDTH+1:2];

    // Grant / wait-state FSM; RESP accepts a new request exactly like IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt       = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (bus.data_req_i) begin
                    if (NO_WAIT) begin
                        w_gnt       = 1'b1;
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_cnt_nxt   = WAIT_LOAD;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.data_req_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_gnt       = 1'b1;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt - GNT_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // A grant during reset would be lost, so it is never offered
        if (rst) begin
            w_gnt = 1'b0;
        end
    end

    // State, counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rd     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rvalid <= w_gnt;
            r_err    <= w_gnt & ~w_in_range;
            r_rd     <= w_gnt & w_in_range & ~bus.data_we_i;
        end
    end

    flexbex_data_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .i_en    (w_gnt & w_in_range),
        .i_we    (bus.data_we_i),
        .i_be    (bus.data_be_i),
        .i_addr  (w_idx),
        .i_wdata (bus.data_wdata_i),
        .o_rdata (w_ram_rdata)
    );

    // RAM output holds stale words; only in-range read responses expose it
    assign bus.data_gnt_o    = w_gnt;
    assign bus.data_rvalid_o = r_rvalid;
    assign bus.data_err_o    = r_err;
    assign bus.data_rdata_o  = r_rd ? w_ram_rdata : '0;

endmodule

// File: tb/tb_flexbex_data_mem_responder.sv
// Self-checking bench: one responder with no grant wait states (1 KiW at base 0)
// and one with GNT_WAIT=3 (64 words at base 0x1000), both checked against a
// word-array reference model kept here.
module tb_flexbex_data_mem_responder;

    localparam int unsigned D0_DEPTH = 1024;
    localparam int unsigned D3_DEPTH = 64;
    localparam logic [31:0] D3_BASE  = 32'h0000_1000;
    localparam int          D3_LAT   = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [31:0] m0 [D0_DEPTH];
    logic [31:0] m3 [D3_DEPTH];

    flexbex_data_mem_responder_if b0 ();
    flexbex_data_mem_responder_if b3 ();

    flexbex_data_mem_responder #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (32'h0000_0000),
        .GNT_WAIT   (0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    flexbex_data_mem_responder #(
        .ADDR_WIDTH (6),
        .BASE_ADDR  (D3_BASE),
        .GNT_WAIT   (3)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (wd & mask);
    endfunction

    task automatic model0(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd);
        logic [31:0] word;
        word = addr >> 2;
        err = 1'b0;
        rd  = 32'h0;
        if (word >= D0_DEPTH) err = 1'b1;
        else if (we) m0[word] = lane_merge(m0[word], wd, be);
        else rd = m0[word];
    endtask

    task automatic model3(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd);
        logic [31:0] word;
        word = (addr - D3_BASE) >> 2;
        err = 1'b0;
        rd  = 32'h0;
        if (word >= D3_DEPTH) err = 1'b1;
        else if (we) m3[word] = lane_merge(m3[word], wd, be);
        else rd = m3[word];
    endtask

    // ---------------- bus drivers (no checking) ----------------
    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        b0.data_req_i   = req;
        b0.data_we_i    = we;
        b0.data_addr_i  = addr;
        b0.data_be_i    = be;
        b0.data_wdata_i = wd;
    endtask

    task automatic drive3(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
        b3.data_req_i   = req;
        b3.data_we_i    = we;
        b3.data_addr_i  = addr;
        b3.data_be_i    = be;
        b3.data_wdata_i = wd;
    endtask

    // Single transfer on dut0: grant sampled in the request cycle, response one cycle later
    task automatic xfer0(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output logic gnt, output logic rv,
                         output logic err, output logic [31:0] rd);
        @(negedge clk);
        drive0(1'b1, we, addr, be, wd);
        #1 gnt = b0.data_gnt_o;
        @(negedge clk);
        rv  = b0.data_rvalid_o;
        err = b0.data_err_o;
        rd  = b0.data_rdata_o;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Single transfer on dut3: request held until granted; lat = cycle of grant (0 = never)
    task automatic xfer3(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output int lat, output logic rv,
                         output logic err, output logic [31:0] rd);
        @(negedge clk);
        drive3(1'b1, we, addr, be, wd);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (b3.data_gnt_o) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        rv  = b3.data_rvalid_o;
        err = b3.data_err_o;
        rd  = b3.data_rdata_o;
        drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        drive3(1'b1, 1'b0, D3_BASE, 4'hF, 32'h0);
        #1;
        tests++; if (b0.data_gnt_o !== 1'b0) begin fails++; $display("FAIL reset_gnt0: got %b want 0", b0.data_gnt_o); end
        tests++; if (b3.data_gnt_o !== 1'b0) begin fails++; $display("FAIL reset_gnt3: got %b want 0", b3.data_gnt_o); end
        @(negedge clk);
        tests++; if (b0.data_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid0: got %b want 0", b0.data_rvalid_o); end
        tests++; if (b0.data_err_o !== 1'b0) begin fails++; $display("FAIL reset_err0: got %b want 0", b0.data_err_o); end
        tests++; if (b0.data_rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata0: got %h want 0", b0.data_rdata_o); end
        tests++; if (b3.data_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_rvalid3: got %b want 0", b3.data_rvalid_o); end
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (b0.data_rvalid_o !== 1'b0) begin fails++; $display("FAIL reset_no_resp0: got %b want 0", b0.data_rvalid_o); end
    endtask

    // Give every RAM word a known value so all later reads are predictable
    task automatic test_init;
        logic e;
        logic [31:0] r;
        logic rv;
        int lat;
        for (int i = 0; i < int'(D0_DEPTH); i++) begin
            @(negedge clk);
            drive0(1'b1, 1'b1, 32'(i) << 2, 4'hF, $urandom());
            model0(1'b1, b0.data_addr_i, 4'hF, b0.data_wdata_i, e, r);
        end
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int i = 0; i < int'(D3_DEPTH); i++) begin
            logic [31:0] wd;
            wd = $urandom();
            model3(1'b1, D3_BASE + (32'(i) << 2), 4'hF, wd, e, r);
            xfer3(1'b1, D3_BASE + (32'(i) << 2), 4'hF, wd, lat, rv, e, r);
        end
    endtask

    task automatic test_basic_rw;
        logic g, rv, e, me;
        logic [31:0] rd, mr;
        model0(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, me, mr);
        xfer0(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, g, rv, e, rd);
        tests++; if (g !== 1'b1) begin fails++; $display("FAIL basic_wr_gnt: got %b want 1", g); end
        tests++; if (rv !== 1'b1) begin fails++; $display("FAIL basic_wr_rvalid: got %b want 1", rv); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL basic_wr_rdata: got %h want 0", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL basic_wr_err: got %b want 0", e); end
        xfer0(1'b0, 32'h10, 4'hF, 32'h0, g, rv, e, rd);
        tests++; if (g !== 1'b1) begin fails++; $display("FAIL basic_rd_gnt: got %b want 1", g); end
        tests++; if (rv !== 1'b1) begin fails++; $display("FAIL basic_rd_rvalid: got %b want 1", rv); end
        tests++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_rd_rdata: got %h want deadbeef", rd); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL basic_rd_err: got %b want 0", e); end
        @(negedge clk);
        tests++; if (b0.data_rvalid_o !== 1'b0) begin fails++; $display("FAIL idle_rvalid: got %b want 0", b0.data_rvalid_o); end
        tests++; if (b0.data_rdata_o !== 32'h0) begin fails++; $display("FAIL idle_rdata: got %h want 0", b0.data_rdata_o); end
    endtask

    task automatic test_be_merge;
        logic g, rv, e, me;
        logic [31:0] rd, mr;
        model0(1'b1, 32'h20, 4'hF, 32'h1122_3344, me, mr);
        xfer0(1'b1, 32'h20, 4'hF, 32'h1122_3344, g, rv, e, rd);
        model0(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, me, mr);
        xfer0(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, g, rv, e, rd);
        xfer0(1'b0, 32'h20, 4'h0, 32'h0, g, rv, e, rd);
        tests++; if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL be_merge: got %h want 11bb33dd", rd); end
        // be=0 write: normal response, word unchanged; low address bits ignored
        xfer0(1'b1, 32'h23, 4'h0, 32'hFFFF_FFFF, g, rv, e, rd);
        tests++; if (rv !== 1'b1 || e !== 1'b0) begin fails++; $display("FAIL be_zero_resp: got rv=%b err=%b want rv=1 err=0", rv, e); end
        xfer0(1'b0, 32'h22, 4'h0, 32'h0, g, rv, e, rd);
        tests++; if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL be_zero_keep: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_range;
        logic g, rv, e;
        logic [31:0] rd;
        int lat;
        xfer0(1'b1, 32'h1000, 4'hF, 32'h5A5A_5A5A, g, rv, e, rd);
        tests++; if (rv !== 1'b1 || e !== 1'b1) begin fails++; $display("FAIL oor_wr: got rv=%b err=%b want 1 1", rv, e); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_wr_rdata: got %h want 0", rd); end
        xfer0(1'b0, 32'h0, 4'hF, 32'h0, g, rv, e, rd);
        tests++; if (rd !== m0[0] || e !== 1'b0) begin fails++; $display("FAIL oor_no_alias: got %h err=%b want %h err=0", rd, e, m0[0]); end
        xfer0(1'b0, 32'h0FFC, 4'hF, 32'h0, g, rv, e, rd);
        tests++; if (rd !== m0[1023] || e !== 1'b0) begin fails++; $display("FAIL top_word: got %h err=%b want %h err=0", rd, e, m0[1023]); end
        xfer0(1'b0, 32'h1000, 4'hF, 32'h0, g, rv, e, rd);
        tests++; if (rd !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL oor_rd: got %h err=%b want 0 err=1", rd, e); end
        // Just below a nonzero base wraps to a huge offset
        xfer3(1'b0, D3_BASE - 32'h4, 4'hF, 32'h0, lat, rv, e, rd);
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL below_base: got %h err=%b want 0 err=1", rd, e); end
        xfer3(1'b0, D3_BASE + 32'hFC, 4'hF, 32'h0, lat, rv, e, rd);
        tests++; if (e !== 1'b0 || rd !== m3[63]) begin fails++; $display("FAIL base_top_word: got %h err=%b want %h err=0", rd, e, m3[63]); end
    endtask

    task automatic test_back_to_back;
        logic g1, g2, v1, v2, v3;
        logic [31:0] d1, d2;
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        #1 g1 = b0.data_gnt_o;
        @(negedge clk);
        v1 = b0.data_rvalid_o;
        d1 = b0.data_rdata_o;
        drive0(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        #1 g2 = b0.data_gnt_o;
        @(negedge clk);
        v2 = b0.data_rvalid_o;
        d2 = b0.data_rdata_o;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        v3 = b0.data_rvalid_o;
        tests++; if (g1 !== 1'b1 || g2 !== 1'b1) begin fails++; $display("FAIL b2b_gnt: got %b%b want 11", g1, g2); end
        tests++; if (v1 !== 1'b1 || v2 !== 1'b1 || v3 !== 1'b0) begin fails++; $display("FAIL b2b_rvalid: got %b%b%b want 110", v1, v2, v3); end
        tests++; if (d1 !== m0[0]) begin fails++; $display("FAIL b2b_data0: got %h want %h", d1, m0[0]); end
        tests++; if (d2 !== m0[1]) begin fails++; $display("FAIL b2b_data1: got %h want %h", d2, m0[1]); end
    endtask

    task automatic test_wait_states;
        logic g [9];
        logic v [9];
        logic [31:0] d [9];
        logic req_on, rv, e;
        logic [31:0] rd;
        int lat;
        for (int pass = 0; pass < 2; pass++) begin
            req_on = 1'b1;
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                v[c] = b3.data_rvalid_o;
                d[c] = b3.data_rdata_o;
                if (pass == 1 && c >= 2) req_on = 1'b0;
                drive3(req_on, 1'b0, D3_BASE + 32'h8, 4'hF, 32'h0);
                #1 g[c] = b3.data_gnt_o;
                if (g[c]) req_on = 1'b0;
            end
            for (int c = 1; c <= 8; c++) begin
                tests++; if (g[c] !== (pass == 0 && c == D3_LAT)) begin fails++; $display("FAIL wait_gnt p%0d c%0d: got %b", pass, c, g[c]); end
                tests++; if (v[c] !== (pass == 0 && c == D3_LAT + 1)) begin fails++; $display("FAIL wait_rvalid p%0d c%0d: got %b", pass, c, v[c]); end
            end
            if (pass == 0) begin
                tests++; if (d[D3_LAT + 1] !== m3[2]) begin fails++; $display("FAIL wait_rdata: got %h want %h", d[D3_LAT + 1], m3[2]); end
            end
        end
        drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        // After an abandoned request the full wait applies again
        xfer3(1'b0, D3_BASE + 32'hC, 4'hF, 32'h0, lat, rv, e, rd);
        tests++; if (lat !== D3_LAT) begin fails++; $display("FAIL wait_after_drop: got %0d want %0d", lat, D3_LAT); end
        tests++; if (rd !== m3[3]) begin fails++; $display("FAIL wait_after_drop_data: got %h want %h", rd, m3[3]); end
    endtask

    task automatic test_reset_mid;
        logic g, rv, e;
        logic [31:0] rd, prev;
        prev = m0[12];
        @(negedge clk);
        drive0(1'b1, 1'b1, 32'h30, 4'hF, ~prev);
        rst = 1'b1;
        #1 g = b0.data_gnt_o;
        tests++; if (g !== 1'b0) begin fails++; $display("FAIL rstmid_gnt: got %b want 0", g); end
        @(negedge clk);
        tests++; if (b0.data_rvalid_o !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid: got %b want 0", b0.data_rvalid_o); end
        rst = 1'b0;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        tests++; if (b0.data_rvalid_o !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid2: got %b want 0", b0.data_rvalid_o); end
        xfer0(1'b0, 32'h30, 4'hF, 32'h0, g, rv, e, rd);
        tests++; if (rd !== prev) begin fails++; $display("FAIL rstmid_keep: got %h want %h", rd, prev); end
    endtask

    function automatic logic [31:0] rand_addr0();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return $urandom();
        if (sel == 1) return 32'h1000 + 32'($urandom_range(0, 255));
        return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Random stream at one transfer per cycle; responses checked every cycle
    task automatic test_random_stream;
        logic exp_rv, exp_err, req;
        logic [31:0] exp_rd, addr, wd;
        logic we;
        logic [3:0] be;
        exp_rv = 1'b0; exp_err = 1'b0; exp_rd = 32'h0;
        for (int c = 0; c <= 400; c++) begin
            @(negedge clk);
            tests++; if (b0.data_rvalid_o !== exp_rv) begin fails++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, b0.data_rvalid_o, exp_rv); end
            tests++; if (b0.data_err_o !== exp_err) begin fails++; $display("FAIL rnd_err c%0d: got %b want %b", c, b0.data_err_o, exp_err); end
            tests++; if (b0.data_rdata_o !== exp_rd) begin fails++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, b0.data_rdata_o, exp_rd); end
            req  = (c < 400) && ($urandom_range(0, 3) != 0);
            we   = 1'($urandom_range(0, 1));
            addr = rand_addr0();
            be   = 4'($urandom_range(0, 15));
            wd   = $urandom();
            drive0(req, we, addr, be, wd);
            exp_rv = req;
            if (req) model0(we, addr, be, wd, exp_err, exp_rd);
            else begin exp_err = 1'b0; exp_rd = 32'h0; end
            #1;
            tests++; if (b0.data_gnt_o !== req) begin fails++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, b0.data_gnt_o, req); end
        end
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_random_wait;
        logic we, rv, e, me;
        logic [31:0] addr, wd, rd, mr;
        logic [3:0] be;
        int lat;
        int unsigned sel;
        for (int i = 0; i < 60; i++) begin
            sel  = $urandom_range(0, 5);
            if (sel == 0) addr = D3_BASE - (32'($urandom_range(1, 64)) << 2);
            else if (sel == 1) addr = D3_BASE + 32'h100 + 32'($urandom_range(0, 1023));
            else addr = D3_BASE + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
            we = 1'($urandom_range(0, 1));
            be = 4'($urandom_range(0, 15));
            wd = $urandom();
            model3(we, addr, be, wd, me, mr);
            xfer3(we, addr, be, wd, lat, rv, e, rd);
            tests++; if (lat !== D3_LAT || rv !== 1'b1) begin fails++; $display("FAIL rndw_timing %0d: lat=%0d rv=%b want lat=%0d rv=1", i, lat, rv, D3_LAT); end
            tests++; if (e !== me || rd !== mr) begin fails++; $display("FAIL rndw_resp %0d: got %h err=%b want %h err=%b", i, rd, e, mr, me); end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        drive0(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive3(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        test_reset;
        test_init;
        test_basic_rw;
        test_be_merge;
        test_range;
        test_back_to_back;
        test_wait_states;
        test_reset_mid;
        test_random_stream;
        test_random_wait;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
